// File: rtl/cal_acc_slave.sv
// cal_acc_slave: CPU-programmed block copier that reads and writes memory once granted the bus.
// Define ACC_READBACK_EN for registered register readback on cpu_data_out.
module cal_acc_slave #(
   parameter logic [15:0] ADDR_ASSH = 16'h0000,
   parameter logic [15:0] ADDR_ASSL = 16'h0001,
   parameter logic [15:0] ADDR_ASTH = 16'h0002,
   parameter logic [15:0] ADDR_ASTL = 16'h0003,
   parameter logic [15:0] ADDR_SREG = 16'h0004,
   parameter int          BLOCK_LEN = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] cpu_addr_in,
   input  logic [7:0]  cpu_data_in,
   input  logic        cpu_write,
   output logic [7:0]  cpu_data_out,
   output logic        acc_req,
   input  logic        acc_gnt,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   output logic        acc_int
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_RD,
      S_WAIT,
      S_WR,
      S_DONE
   } state_t;

   state_t      state, state_nx;
   logic [7:0]  assh, assl, asth, astl;
   logic [15:0] src, tgt;
   logic [8:0]  remain;
   logic [7:0]  rdata_q;
   logic        rd_q;
   logic        done;
   logic        busy;
   logic        reg_wr;
   logic        start;
   logic        last;

   assign busy   = (state != S_IDLE);
   assign reg_wr = cpu_write && !busy;
   assign start  = reg_wr && (cpu_addr_in == ADDR_SREG) && cpu_data_in[7];
   assign last   = (remain == 9'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: if (start) state_nx = S_REQ;
         S_REQ:  if (acc_gnt) state_nx = S_RD;
         S_RD:   if (acc_gnt) state_nx = S_WAIT;
         S_WAIT: if (acc_gnt) state_nx = S_WR;
         S_WR:   if (acc_gnt) state_nx = last ? S_DONE : S_RD;
         S_DONE: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Strobes are gated by the grant so a dropped grant freezes the bus cleanly.
   always_comb begin
      acc_req   = (state == S_REQ) || (state == S_RD) ||
                  (state == S_WAIT) || (state == S_WR);
      mem_rd    = (state == S_RD) && acc_gnt;
      mem_wr    = (state == S_WR) && acc_gnt;
      mem_addr  = 16'h0000;
      mem_wdata = 8'h00;
      if (mem_rd) begin
         mem_addr = src;
      end else if (mem_wr) begin
         mem_addr  = tgt;
         mem_wdata = rdata_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         assh    <= 8'h00;
         assl    <= 8'h00;
         asth    <= 8'h00;
         astl    <= 8'h00;
         src     <= 16'h0000;
         tgt     <= 16'h0000;
         remain  <= 9'd0;
         rdata_q <= 8'h00;
         rd_q    <= 1'b0;
         done    <= 1'b0;
      end else begin
         rd_q <= mem_rd;
         // Read data arrives the cycle after the strobe, even if the grant drops.
         if (rd_q) rdata_q <= mem_rdata;
         if (reg_wr) begin
            case (cpu_addr_in)
               ADDR_ASSH: assh <= cpu_data_in;
               ADDR_ASSL: assl <= cpu_data_in;
               ADDR_ASTH: asth <= cpu_data_in;
               ADDR_ASTL: astl <= cpu_data_in;
               ADDR_SREG: done <= 1'b0;
               default: ;
            endcase
         end
         if (start) begin
            src    <= {assh, assl};
            tgt    <= {asth, astl};
            remain <= 9'(BLOCK_LEN);
         end
         if (mem_wr) begin
            src    <= src + 16'd1;
            tgt    <= tgt + 16'd1;
            remain <= remain - 9'd1;
         end
         if (state == S_DONE) done <= 1'b1;
      end
   end

   assign acc_int = done;

`ifdef ACC_READBACK_EN
   logic [7:0] rb_d;

   always_comb begin
      rb_d = 8'h00;
      case (cpu_addr_in)
         ADDR_ASSH: rb_d = assh;
         ADDR_ASSL: rb_d = assl;
         ADDR_ASTH: rb_d = asth;
         ADDR_ASTL: rb_d = astl;
         ADDR_SREG: rb_d = {6'b0, done, busy};
         default:   rb_d = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpu_data_out <= 8'h00;
      end else begin
         cpu_data_out <= rb_d;
      end
   end
`else
   assign cpu_data_out = 8'h00;
`endif

endmodule

// File: tb/tb_cal_acc_slave.sv
// tb_cal_acc_slave: randomized block copies checked by a queue scoreboard
// against a byte-level model of the copy, plus reset and grant-gap cases.
module tb_cal_acc_slave;

   localparam int          LEN    = 16;
   localparam logic [15:0] A_ASSH = 16'h0000;
   localparam logic [15:0] A_ASSL = 16'h0001;
   localparam logic [15:0] A_ASTH = 16'h0002;
   localparam logic [15:0] A_ASTL = 16'h0003;
   localparam logic [15:0] A_SREG = 16'h0004;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] cpu_addr_in = 16'h0;
   logic [7:0]  cpu_data_in = 8'h0;
   logic        cpu_write = 1'b0;
   logic [7:0]  cpu_data_out;
   logic        acc_req;
   logic        acc_gnt = 1'b1;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic        mem_wr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata = 8'h0;
   logic        acc_int;

   always #5 clk = ~clk;

   cal_acc_slave #(.BLOCK_LEN(LEN)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .cpu_addr_in(cpu_addr_in),
      .cpu_data_in(cpu_data_in),
      .cpu_write(cpu_write),
      .cpu_data_out(cpu_data_out),
      .acc_req(acc_req),
      .acc_gnt(acc_gnt),
      .mem_addr(mem_addr),
      .mem_rd(mem_rd),
      .mem_wr(mem_wr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .acc_int(acc_int)
   );

   logic [7:0] mem [0:65535];

   always @(posedge clk) begin
      if (mem_rd) mem_rdata <= mem[mem_addr];
      if (mem_wr) mem[mem_addr] <= mem_wdata;
   end

   int          tests = 0;
   int          fails = 0;
   int          wr_seen = 0;
   logic [15:0] rd_exp[$];
   logic [23:0] wr_exp[$];

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever a strobe is presented.
   always @(negedge clk) begin
      if (rst_n) begin
         if (!acc_gnt) check("no_strobe_without_gnt", {62'b0, mem_rd, mem_wr}, 0);
         if (mem_rd || mem_wr) begin
            check("strobe_exclusive", 64'(mem_rd & mem_wr), 0);
            check("acc_req_during_xfer", 64'(acc_req), 1);
         end
         if (mem_rd) begin
            if (rd_exp.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL rd_unexpected: got addr %0h expected none", mem_addr);
            end else begin
               check("rd_addr", 64'(mem_addr), 64'(rd_exp.pop_front()));
            end
         end
         if (mem_wr) begin
            wr_seen++;
            if (wr_exp.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL wr_unexpected: got %0h expected none", {mem_addr, mem_wdata});
            end else begin
               check("wr_addr_data", 64'({mem_addr, mem_wdata}), 64'(wr_exp.pop_front()));
            end
         end
      end
   end

   // Reference: byte i is read from src+i and written to tgt+i, 16-bit wrap.
   task automatic expect_xfer(input logic [15:0] s, input logic [15:0] t);
      logic [15:0] a;
      for (int i = 0; i < LEN; i++) begin
         a = s + 16'(i);
         rd_exp.push_back(a);
         wr_exp.push_back({t + 16'(i), mem[a]});
      end
   endtask

   task automatic reg_wr(input logic [15:0] a, input logic [7:0] d);
      cpu_addr_in = a;
      cpu_data_in = d;
      cpu_write   = 1'b1;
      @(posedge clk);
      #1 cpu_write = 1'b0;
   endtask

   task automatic program_regs(input logic [15:0] s, input logic [15:0] t);
      reg_wr(A_ASSH, s[15:8]);
      reg_wr(A_ASSL, s[7:0]);
      reg_wr(A_ASTH, t[15:8]);
      reg_wr(A_ASTL, t[7:0]);
   endtask

   task automatic run(input logic [15:0] s, input logic [15:0] t,
                      input bit prog, input bit gap, input bit poke);
      int cyc;
      int expc;
      int gap_left;
      bit gapped;
      cyc = 0;
      gap_left = 0;
      gapped = 1'b0;
      if (prog) program_regs(s, t);
      expect_xfer(s, t);
      wr_seen = 0;
      reg_wr(A_SREG, 8'h80);
      check("start_clears_int", 64'(acc_int), 0);
      check("req_after_start", 64'(acc_req), 1);
      // One request cycle, three cycles per byte, one done cycle.
      expc = 3 * LEN + 2 + (gap ? 5 : 0);
      while (!acc_int && cyc < 500) begin
         @(posedge clk);
         #1 cyc++;
         cpu_write = 1'b0;
         if (gap_left > 0) begin
            gap_left--;
            if (gap_left == 0) acc_gnt = 1'b1;
         end else if (gap && !gapped && wr_seen == 3) begin
            acc_gnt  = 1'b0;
            gap_left = 5;
            gapped   = 1'b1;
         end
         if (poke) begin
            if (cyc == 5) begin
               cpu_addr_in = A_ASSL;
               cpu_data_in = 8'h55;
               cpu_write   = 1'b1;
            end else if (cyc == 6) begin
               cpu_addr_in = A_SREG;
               cpu_data_in = 8'h80;
               cpu_write   = 1'b1;
            end else if (cyc == 7) begin
               cpu_addr_in = A_SREG;
            end
`ifdef ACC_READBACK_EN
            if (cyc == 8) check("sreg_busy_readback", 64'(cpu_data_out), 64'h01);
`endif
         end
      end
      acc_gnt = 1'b1;
      check("done_latency", 64'(cyc), 64'(expc));
      check("rd_queue_drained", 64'(rd_exp.size()), 0);
      check("wr_queue_drained", 64'(wr_exp.size()), 0);
      check("req_low_after_done", 64'(acc_req), 0);
      rd_exp.delete();
      wr_exp.delete();
   endtask

   task automatic check_all_zero(input string name);
      check(name, {23'b0, acc_req, mem_rd, mem_wr, mem_addr, mem_wdata,
                   acc_int, cpu_data_out}, 0);
   endtask

   logic [15:0] rs, rt;
   int          k;

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      #12;
      check_all_zero("reset_outputs");
      @(posedge clk);
      #1 rst_n = 1'b1;

      run(16'h1000, 16'h2000, 1'b1, 1'b0, 1'b0);
      check("int_level_held", 64'(acc_int), 1);
      run(16'hFFFE, 16'h3000, 1'b1, 1'b0, 1'b0);
      run(16'h4321, 16'hA000, 1'b1, 1'b1, 1'b0);

      rs = 16'($urandom);
      rt = rs + 16'h4000 + 16'($urandom_range(0, 16'h7000));
      run(rs, rt, 1'b1, 1'b0, 1'b1);
      // Registers still hold rs/rt because the busy-time writes were dropped.
      run(rs, rt, 1'b0, 1'b0, 1'b0);

      reg_wr(A_SREG, 8'h00);
      check("sreg_clear_int", 64'(acc_int), 0);
      reg_wr(16'h0077, 8'h80);
      check("unmatched_addr_no_start", 64'(acc_req), 0);

      for (int n = 0; n < 4; n++) begin
         rs = 16'($urandom);
         rt = rs + 16'h4000 + 16'($urandom_range(0, 16'h7000));
         run(rs, rt, 1'b1, n[0], 1'b0);
      end

      rs = 16'h5000;
      rt = 16'hC000;
      program_regs(rs, rt);
      expect_xfer(rs, rt);
      wr_seen = 0;
      reg_wr(A_SREG, 8'h80);
      k = 0;
      while (!(mem_wr && wr_seen >= 2) && k < 200) begin
         @(posedge clk);
         #1 k++;
      end
      check("reached_mid_wr", 64'(mem_wr), 1);
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_reset_mid_wr");
      rd_exp.delete();
      wr_exp.delete();
      repeat (2) @(posedge clk);
      #1 check_all_zero("reset_held");
      rst_n = 1'b1;
      run(16'h6000, 16'hD000, 1'b1, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
